sisc_seq_ctrl: RTL

Parametrised, variable-length multi-cycle control FSM for the SISC CPU. It is the successor to the fixed seven-state controller. Each instruction walks only the phases it needs. Instruction and data memory accesses stall on a `mem_ready` handshake, and SWP gets a two-cycle writeback. HLT is handled in hardware as a sticky HALT state, and a retired-instruction counter is provided. It sits between the IR/status register and the datapath (PC, register file, ALU, memory muxes).

---
 rtl/sisc_seq_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sisc_seq_ctrl.sv
// ============================================================================
// Module   : sisc_seq_ctrl
// Brief    : Variable-length multi-cycle control FSM for the SISC CPU with
//            memory handshake stalls, two-cycle SWP writeback, sticky HALT
//            and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sisc_seq_ctrl #(
    parameter int OP_W   = 4,
    parameter int CC_W   = 4,
    parameter int AM_IMM = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             mem_ready,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             ir_load,
    output logic             rd_sel,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             swap_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] c_ST_RESET   = 4'd0;
    localparam logic [3:0] c_ST_FETCH   = 4'd1;
    localparam logic [3:0] c_ST_DECODE  = 4'd2;
    localparam logic [3:0] c_ST_EXECUTE = 4'd3;
    localparam logic [3:0] c_ST_MEM     = 4'd4;
    localparam logic [3:0] c_ST_WB      = 4'd5;
    localparam logic [3:0] c_ST_WB2     = 4'd6;
    localparam logic [3:0] c_ST_HALT    = 4'd7;

    localparam logic [OP_W-1:0] c_OP_NOOP = OP_W'(0);
    localparam logic [OP_W-1:0] c_OP_LOD  = OP_W'(1);
    localparam logic [OP_W-1:0] c_OP_STR  = OP_W'(2);
    localparam logic [OP_W-1:0] c_OP_SWP  = OP_W'(3);
    localparam logic [OP_W-1:0] c_OP_BRA  = OP_W'(4);
    localparam logic [OP_W-1:0] c_OP_BRR  = OP_W'(5);
    localparam logic [OP_W-1:0] c_OP_BNE  = OP_W'(6);
    localparam logic [OP_W-1:0] c_OP_BNR  = OP_W'(7);
    localparam logic [OP_W-1:0] c_OP_ALU  = OP_W'(8);
    localparam logic [OP_W-1:0] c_OP_HLT  = OP_W'(15);

    localparam logic [CC_W-1:0] c_AM_IMM = CC_W'(AM_IMM);

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_instret;
    logic             w_is_rel;
    logic             w_is_cond_pos;
    logic             w_is_branch;
    logic             w_is_mem_op;
    logic             w_taken;

    assign w_is_rel      = (opcode == c_OP_BRR) || (opcode == c_OP_BNR);
    assign w_is_cond_pos = (opcode == c_OP_BRA) || (opcode == c_OP_BRR);
    assign w_is_branch   = w_is_cond_pos || (opcode == c_OP_BNE) || (opcode == c_OP_BNR);
    assign w_is_mem_op   = (opcode == c_OP_LOD) || (opcode == c_OP_STR);
    // An all-zero mask is an unconditional branch for every branch flavour.
    assign w_taken       = (mm == '0) ||
                           (w_is_cond_pos ? ((stat & mm) != '0) : ((stat & mm) == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_RESET;
            r_instret <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_ST_DECODE) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = c_ST_RESET;
        pc_rst       = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 1'b0;
        br_sel       = 1'b1;
        ir_load      = 1'b0;
        rd_sel       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        swap_sel     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        halted       = 1'b0;
        alu_op       = 2'b10;

        case (r_state)
            c_ST_RESET: begin
                pc_rst       = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                mem_req      = 1'b1;
                w_next_state = c_ST_FETCH;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                br_sel = ~w_is_rel;
                case (opcode)
                    c_OP_HLT:                     w_next_state = c_ST_HALT;
                    c_OP_LOD, c_OP_STR, c_OP_SWP,
                    c_OP_BRA, c_OP_BRR, c_OP_BNE,
                    c_OP_BNR, c_OP_ALU:           w_next_state = c_ST_EXECUTE;
                    default:                      w_next_state = c_ST_FETCH;
                endcase
            end
            c_ST_EXECUTE: begin
                alu_op = {opcode != c_OP_ALU, mm == c_AM_IMM};
                br_sel = ~w_is_rel;
                rd_sel = w_is_mem_op;
                if (w_is_branch && w_taken) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                end
                if (w_is_mem_op) begin
                    w_next_state = c_ST_MEM;
                end else if ((opcode == c_OP_ALU) || (opcode == c_OP_SWP)) begin
                    w_next_state = c_ST_WB;
                end else begin
                    w_next_state = c_ST_FETCH;
                end
            end
            c_ST_MEM: begin
                mem_req      = 1'b1;
                rd_sel       = 1'b1;
                mem_we       = (opcode == c_OP_STR);
                w_next_state = c_ST_MEM;
                if (mem_ready) begin
                    w_next_state = (opcode == c_OP_LOD) ? c_ST_WB : c_ST_FETCH;
                end
            end
            c_ST_WB: begin
                rf_we        = 1'b1;
                wb_sel       = (opcode == c_OP_LOD);
                w_next_state = (opcode == c_OP_SWP) ? c_ST_WB2 : c_ST_FETCH;
            end
            c_ST_WB2: begin
                rf_we        = 1'b1;
                swap_sel     = 1'b1;
                w_next_state = c_ST_FETCH;
            end
            c_ST_HALT: begin
                halted       = 1'b1;
                w_next_state = c_ST_HALT;
            end
            default: begin
                w_next_state = c_ST_RESET;
            end
        endcase
    end

    assign state   = r_state;
    assign instret = r_instret;

    // c_OP_NOOP documents the encoding; NOOP falls through the decode default.
    logic w_unused;
    assign w_unused = (c_OP_NOOP != '0);

endmodule

`default_nettype wire
